// File: rtl/mem_access_unit.sv
// Load/store sequencer for a 16-bit big-endian data memory with a handshake front end.
// Optional macro MEM_ACCESS_RO_GUARD_EN rejects stores touching bytes 0x4E..0x50.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   write_q;
  logic   illegal_c;

  // The second byte of a word at the top address would wrap to zero.
  always_comb begin
    illegal_c = (req_addr == {ADDR_W{1'b1}});
`ifdef MEM_ACCESS_RO_GUARD_EN
    if (req_write && (req_addr >= ADDR_W'(32'h4D)) && (req_addr <= ADDR_W'(32'h50)))
      illegal_c = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      write_q      <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            write_q     <= req_write;
            mem_address <= req_addr;
            mem_wdata   <= req_wdata;
            resp_rdata  <= '0;
            if (illegal_c) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
              state        <= ISSUE;
              mem_read_en  <= ~req_write;
              mem_write_en <= req_write;
            end
          end
        end
        ISSUE: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          if (!write_q) resp_rdata <= mem_rdata;
          resp_valid   <= 1'b1;
          resp_err     <= 1'b0;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          resp_valid   <= 1'b0;
          req_ready    <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected strobes/responses, monitors pop and compare.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_address;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic [7:0]  err_count;

  typedef struct {logic [15:0] rdata; logic err;} resp_t;
  typedef struct {logic wr; logic [7:0] addr; logic [15:0] wdata;} strb_t;

  resp_t resp_q[$];
  strb_t strb_q[$];
  int total = 0;
  int bad = 0;
  logic guard_legal;

  mem_access_unit #(.ADDR_W(8), .DATA_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Memory-side monitor: every strobe must match the next expected one and last one cycle.
  always @(negedge CLK) begin
    if (RST_N && (mem_read_en || mem_write_en)) begin
      chk("strobe_exclusive", {31'd0, mem_read_en & mem_write_en}, 32'd0);
      if (strb_q.size() == 0) begin
        chk("unexpected_strobe", {24'd0, mem_address}, 32'hFFFF_FFFF);
      end else begin
        strb_t e;
        e = strb_q.pop_front();
        chk("strobe_write", {31'd0, mem_write_en}, {31'd0, e.wr});
        chk("strobe_addr", {24'd0, mem_address}, {24'd0, e.addr});
        if (e.wr) chk("strobe_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
      end
    end
  end

  // Response monitor: compares on each accepted response.
  always @(negedge CLK) begin
    if (RST_N && resp_valid && resp_ready) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", {16'd0, resp_rdata}, 32'hFFFF_FFFF);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic issue(input logic wr, input logic [7:0] a, input logic [15:0] d,
                       input logic legal, input logic [15:0] exp_rdata);
    int n;
    resp_t r;
    strb_t s;
    n = 0;
    @(negedge CLK);
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    r.rdata = (legal && !wr) ? exp_rdata : 16'h0000;
    r.err = ~legal;
    resp_q.push_back(r);
    if (legal) begin
      s.wr = wr; s.addr = a; s.wdata = d;
      strb_q.push_back(s);
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || strb_q.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_resp_q", resp_q.size(), 32'd0);
    chk("drain_strb_q", strb_q.size(), 32'd0);
  endtask

  initial begin
`ifdef MEM_ACCESS_RO_GUARD_EN
    guard_legal = 1'b0;
`else
    guard_legal = 1'b1;
`endif
    // Reset values while reset is held.
    #12;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst_mem_address", {24'd0, mem_address}, 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Load with cycle-accurate latency checks.
    mem_rdata = 16'h1234;
    issue(1'b0, 8'h40, 16'h0000, 1'b1, 16'h1234);
    @(negedge CLK);
    chk("load_strobe_cycle", {31'd0, mem_read_en}, 32'd1);
    chk("load_no_early_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge CLK);
    chk("load_resp_cycle", {31'd0, resp_valid}, 32'd1);
    chk("load_strobe_dropped", {31'd0, mem_read_en}, 32'd0);
    @(negedge CLK);
    chk("load_ready_e2", {31'd0, req_ready}, 32'd1);

    // Store; memory read data is garbage and must not leak into the response.
    mem_rdata = 16'hFFFF;
    issue(1'b1, 8'h44, 16'hA5C3, 1'b1, 16'h0000);
    // Wrap boundary.
    issue(1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0000);
    drain();
    chk("wrap_err_count", {24'd0, err_count}, 32'd1);
    // Loads from the protected bytes are always legal.
    mem_rdata = 16'h4E4F;
    issue(1'b0, 8'h4E, 16'h0000, 1'b1, 16'h4E4F);
    // Store just outside the protected window.
    issue(1'b1, 8'h51, 16'h1111, 1'b1, 16'h0000);
    // Guarded store.
    issue(1'b1, 8'h4D, 16'h7777, guard_legal, 16'h0000);
    issue(1'b1, 8'h50, 16'h8888, guard_legal, 16'h0000);
    drain();
    chk("guard_err_count", {24'd0, err_count}, guard_legal ? 32'd1 : 32'd3);

    // Backpressure: response held, new request ignored.
    resp_ready = 1'b0;
    mem_rdata = 16'hBEEF;
    issue(1'b0, 8'h20, 16'h0000, 1'b1, 16'hBEEF);
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resp_rdata", {16'd0, resp_rdata}, 32'h0000BEEF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 16'hDEAD;
      @(negedge CLK);
    end
    req_valid = 1'b0;
    mem_rdata = 16'h0000;
    resp_ready = 1'b1;
    drain();

    // Reset during ISSUE.
    @(negedge CLK);
    mem_rdata = 16'h5555;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    chk("mid_issue_strobe", {31'd0, mem_read_en}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_strobe_drop", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Error counter saturation.
    for (int i = 0; i < 258; i++) issue(1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0000);
    drain();
    chk("err_count_sat", {24'd0, err_count}, 32'h000000FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
